// File: rtl/rr_resource_scheduler_if.sv
// Handshake bundle between requesters and the round-robin scheduler.
// Requesters drive req/done/err_clr; the scheduler drives ownership status.
interface rr_resource_scheduler_if #(
  parameter int N = 4
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     req;
  logic [N-1:0]     done;
  logic             err_clr;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             busy;
  logic             timeout;
  logic [IDX_W-1:0] timeout_idx;
  logic             err_sticky;

  modport master (
    output req, done, err_clr,
    input  grant, grant_idx, grant_valid,
    input  busy, timeout, timeout_idx, err_sticky
  );

  modport slave (
    input  req, done, err_clr,
    output grant, grant_idx, grant_valid,
    output busy, timeout, timeout_idx, err_sticky
  );
endinterface

// File: rtl/rr_resource_scheduler.sv
// Round-robin owner scheduler: held grants, release on done/req drop,
// forced release on hold timeout followed by a flush interval.
module rr_resource_scheduler #(
  parameter int N         = 4,
  parameter int TIMEOUT   = 256,
  parameter int FLUSH_LEN = 4
) (
  input logic clk,
  input logic rst,
  rr_resource_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(N);
  localparam int HW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [HW-1:0]    hold_cnt;
  logic [FW-1:0]    flush_cnt;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             busy;
  logic             timeout;
  logic [IDX_W-1:0] timeout_idx;
  logic             err_sticky;

  logic             found;
  logic [IDX_W-1:0] win;
  logic             rel;
  logic             expire;
  logic             err_set;
  logic [IDX_W-1:0] nxt_ptr;

  // Rotating search for the first requester at or after ptr.
  always_comb begin
    int j;
    j = 0;
    found = 1'b0;
    win = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && bus.req[j]) begin
        found = 1'b1;
        win = IDX_W'(j);
      end
    end
  end

  // Release, expiry and protocol-error conditions for the current cycle.
  always_comb begin
    rel = bus.done[grant_idx] | ~bus.req[grant_idx];
    expire = (TIMEOUT != 0) && !rel &&
             (hold_cnt == HW'(TIMEOUT - 1));
    nxt_ptr = (grant_idx == IDX_W'(N - 1)) ? '0
            : grant_idx + 1'b1;
    if (state == GRANT) err_set = |(bus.done & ~grant);
    else                err_set = |bus.done;
  end

  // Ownership FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      flush_cnt   <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      busy        <= 1'b0;
      timeout     <= 1'b0;
      timeout_idx <= '0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            grant     <= {{(N-1){1'b0}}, 1'b1} << win;
            grant_idx <= win;
            hold_cnt  <= '0;
            busy      <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (hold_cnt != {HW{1'b1}})
            hold_cnt <= hold_cnt + 1'b1;
          if (rel) begin
            grant <= '0;
            ptr   <= nxt_ptr;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (expire) begin
            grant       <= '0;
            ptr         <= nxt_ptr;
            timeout     <= 1'b1;
            timeout_idx <= grant_idx;
            flush_cnt   <= '0;
            state       <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_cnt == FW'(FLUSH_LEN - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: begin
          grant <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Sticky error latch; a new error beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)          err_sticky <= 1'b0;
    else if (err_set) err_sticky <= 1'b1;
    else if (bus.err_clr) err_sticky <= 1'b0;
  end

  assign bus.grant       = grant;
  assign bus.grant_idx   = grant_idx;
  assign bus.grant_valid = |grant;
  assign bus.busy        = busy;
  assign bus.timeout     = timeout;
  assign bus.timeout_idx = timeout_idx;
  assign bus.err_sticky  = err_sticky;
endmodule

// File: tb/tb_rr_resource_scheduler.sv
// Directed bench for rr_resource_scheduler (N=4, TIMEOUT=8, FLUSH_LEN=4).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_rr_resource_scheduler;
  localparam int N = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  rr_resource_scheduler_if #(.N(N)) bus ();

  rr_resource_scheduler #(
    .N(N),
    .TIMEOUT(8),
    .FLUSH_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.req = '0;
    bus.done = '0;
    bus.err_clr = 1'b0;
    step();
    step();
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_valid", 32'(bus.grant_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_timeout", 32'(bus.timeout), 0);
    check("rst_toidx", 32'(bus.timeout_idx), 0);
    check("rst_err", 32'(bus.err_sticky), 0);
    rst = 1'b0;

    // Rotation with all requesting: 0,1,2,3,0 and one dead cycle each.
    bus.req = 4'b1111;
    for (int e = 0; e < 5; e++) begin
      int o;
      o = e % N;
      step();
      check("rot_idx", 32'(bus.grant_idx), 32'(o));
      check("rot_grant", 32'(bus.grant), 32'(1 << o));
      step();
      step();
      bus.done = 4'(1 << o);
      step();
      bus.done = '0;
      check("rot_dead", 32'(bus.grant_valid), 0);
      if (e == 4) bus.req = 4'b1001;
    end

    // ptr is now 1: req 1001 must pick 3, then 0.
    step();
    check("skip_first", 32'(bus.grant_idx), 3);
    bus.done = 4'b1000;
    step();
    bus.done = '0;
    check("skip_gap", 32'(bus.grant_valid), 0);
    step();
    check("skip_second", 32'(bus.grant_idx), 0);
    bus.req = '0;
    step();
    check("reqdrop_rel", 32'(bus.grant_valid), 0);
    check("reqdrop_busy", 32'(bus.busy), 0);

    // Single requester held cycles 1..5, done at 5.
    bus.req = 4'b0001;
    for (int c = 1; c <= 5; c++) begin
      step();
      check("single_grant", 32'(bus.grant), 1);
      check("single_busy", 32'(bus.busy), 1);
    end
    bus.done = 4'b0001;
    step();
    bus.done = '0;
    bus.req = '0;
    check("single_rel", 32'(bus.grant), 0);
    check("single_busy6", 32'(bus.busy), 0);

    // Timeout: requester 2 never signals done.
    bus.req = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      step();
      check("to_hold", 32'(bus.grant), 32'h4);
      check("to_nopulse", 32'(bus.timeout), 0);
    end
    step();
    check("to_drop", 32'(bus.grant), 0);
    check("to_pulse", 32'(bus.timeout), 1);
    check("to_idx", 32'(bus.timeout_idx), 2);
    check("to_busy0", 32'(bus.busy), 1);
    for (int c = 1; c < 4; c++) begin
      step();
      check("flush_busy", 32'(bus.busy), 1);
      check("flush_grant", 32'(bus.grant), 0);
      check("flush_pulse", 32'(bus.timeout), 0);
    end
    step();
    check("flush_end_busy", 32'(bus.busy), 0);
    check("flush_end_grant", 32'(bus.grant), 0);
    check("to_idx_held", 32'(bus.timeout_idx), 2);
    step();
    check("regrant_idx", 32'(bus.grant_idx), 2);
    check("regrant_valid", 32'(bus.grant_valid), 1);

    // Done on the expiry cycle: normal release, no flush.
    for (int c = 1; c < 8; c++) step();
    check("exp_still", 32'(bus.grant), 32'h4);
    bus.done = 4'b0100;
    step();
    bus.done = '0;
    bus.req = '0;
    check("exp_rel", 32'(bus.grant), 0);
    check("exp_nopulse", 32'(bus.timeout), 0);
    check("exp_busy", 32'(bus.busy), 0);

    // Non-owner done: error latches, grant unaffected.
    bus.req = 4'b0010;
    step();
    check("err_owner", 32'(bus.grant), 32'h2);
    bus.done = 4'b1000;
    step();
    bus.done = '0;
    check("err_set", 32'(bus.err_sticky), 1);
    check("err_grant", 32'(bus.grant), 32'h2);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("err_clr", 32'(bus.err_sticky), 0);

    // Reset mid-grant; ptr back to 0 so req 1010 picks 1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_grant", 32'(bus.grant), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    bus.req = 4'b1010;
    step();
    check("mid_rst_ptr", 32'(bus.grant_idx), 1);
    bus.req = '0;
    step();
    check("final_rel", 32'(bus.grant_valid), 0);

    // Done in IDLE together with err_clr: set wins.
    bus.done = 4'b0001;
    bus.err_clr = 1'b1;
    step();
    bus.done = '0;
    bus.err_clr = 1'b0;
    check("idle_err_wins", 32'(bus.err_sticky), 1);
    check("idle_err_nogrant", 32'(bus.grant_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
